// File: rtl/collision_engine_if.sv
// Kill-event handshake between the collision engine (master) and whoever
// consumes kill events (slave). hit_row/hit_col are held stable while
// hit_valid is high and hit_ready is low.
interface collision_engine_if #(
  parameter int NUM_ROWS     = 3,
  parameter int NUM_INVADERS = 10
);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;

  logic             hit_valid;
  logic             hit_ready;
  logic [ROW_W-1:0] hit_row;
  logic [COL_W-1:0] hit_col;

  modport master (output hit_valid, hit_row, hit_col, input hit_ready);
  modport slave  (input hit_valid, hit_row, hit_col, output hit_ready);
endinterface

// File: rtl/collision_engine.sv
// Collision engine: on each frame_start, snapshots all projectile and invader
// positions, then checks one projectile channel per cycle against the alive
// invader grid. Each active channel kills at most one invader (lowest row,
// then lowest column) and reports it over the hit_if handshake.
// Optional feature: define COLLISION_ENGINE_SCORE_EN to build the saturating
// kill-score accumulator; otherwise score is tied to zero.
module collision_engine #(
  parameter int NUM_BULLETS       = 4,
  parameter int NUM_INVADERS      = 10,
  parameter int NUM_ROWS          = 3,
  parameter int ROW_OFFSET        = 100,
  parameter int INVADER_WIDTH     = 64,
  parameter int INVADER_HEIGHT    = 32,
  parameter int PROJECTILE_WIDTH  = 16,
  parameter int PROJECTILE_HEIGHT = 32,
  parameter int POINTS            = 10
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         frame_start,
  input  logic                                         wave_reset,
  input  logic [NUM_BULLETS-1:0][11:0]                 bullet_xpos,
  input  logic [NUM_BULLETS-1:0][11:0]                 bullet_ypos,
  input  logic [NUM_BULLETS-1:0]                       bullet_active,
  input  logic [NUM_INVADERS-1:0][11:0]                invader_x_positions,
  input  logic [9:0]                                   enemy_ypos,
  output logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]        alive,
  output logic [NUM_BULLETS-1:0]                       bullet_hit,
  output logic                                         scan_done,
  collision_engine_if.master                           hit_if,
  output logic [$clog2(NUM_ROWS*NUM_INVADERS+1)-1:0]   alive_count,
  output logic                                         all_dead,
  output logic [15:0]                                  score
);

  localparam int BW    = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;
  localparam int CNT_W = $clog2(NUM_ROWS*NUM_INVADERS+1);

  localparam logic [12:0] IW = 13'(INVADER_WIDTH);
  localparam logic [12:0] IH = 13'(INVADER_HEIGHT);
  localparam logic [12:0] PW = 13'(PROJECTILE_WIDTH);
  localparam logic [12:0] PH = 13'(PROJECTILE_HEIGHT);
  localparam logic [NUM_ROWS-1:0][NUM_INVADERS-1:0] ALL_ALIVE = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nxt;

  // Snapshot of the scene taken on IDLE->SCAN
  logic [NUM_BULLETS-1:0][11:0]  bx_q, by_q;
  logic [NUM_BULLETS-1:0]        act_q;
  logic [NUM_INVADERS-1:0][11:0] ix_q;
  logic [9:0]                    ey_q;

  logic [BW-1:0]    b_idx;
  logic             snap, advance, kill_fire;
  logic             kill_found;
  logic [ROW_W-1:0] kill_row;
  logic [COL_W-1:0] kill_col;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Kill search for the current channel: first alive overlapping invader,
  // rows before columns, all arithmetic 13 bits so nothing wraps
  always_comb begin
    logic [12:0] bx, by, ix, ry;
    logic        x_ov, y_ov;
    // NOTE: every variable written here gets a default before any branch,
    // otherwise synthesis infers a latch to hold the old value.
    kill_found = 1'b0;
    kill_row   = '0;
    kill_col   = '0;
    bx = {1'b0, bx_q[b_idx]};
    by = {1'b0, by_q[b_idx]};
    for (int r = 0; r < NUM_ROWS; r++) begin
      ry   = {3'b000, ey_q} + 13'(r * ROW_OFFSET);
      y_ov = (by <= ry + IH) && (by + PH >= ry);
      for (int c = 0; c < NUM_INVADERS; c++) begin
        ix   = {1'b0, ix_q[c]};
        x_ov = (bx < ix + IW) && (bx + PW > ix);
        if (!kill_found && act_q[b_idx] && alive[r][c] && x_ov && y_ov) begin
          kill_found = 1'b1;
          kill_row   = ROW_W'(r);
          kill_col   = COL_W'(c);
        end
      end
    end
  end

  // Next-state and control strobes; wave_reset overrides everything
  always_comb begin
    state_nxt = state;
    scan_done = 1'b0;
    snap      = 1'b0;
    advance   = 1'b0;
    kill_fire = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = SCAN;
          snap      = 1'b1;
        end
      end
      SCAN: begin
        // A kill cannot load while the previous one is still unaccepted
        if (!(kill_found && hit_if.hit_valid && !hit_if.hit_ready)) begin
          advance   = 1'b1;
          kill_fire = kill_found;
          if (b_idx == BW'(NUM_BULLETS-1)) state_nxt = DONE;
        end
      end
      DONE: begin
        scan_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (wave_reset) begin
      state_nxt = IDLE;
      scan_done = 1'b0;
      snap      = 1'b0;
      advance   = 1'b0;
      kill_fire = 1'b0;
    end
  end

  // Scene snapshot capture
  always_ff @(posedge clk) begin
    // NOTE: the snapshot is pure data that is always written before it is
    // read, so it carries no reset.
    if (snap) begin
      bx_q  <= bullet_xpos;
      by_q  <= bullet_ypos;
      act_q <= bullet_active;
      ix_q  <= invader_x_positions;
      ey_q  <= enemy_ypos;
    end
  end

  // Alive mask, per-channel results, channel index and kill handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      alive            <= ALL_ALIVE;
      bullet_hit       <= '0;
      b_idx            <= '0;
      hit_if.hit_valid <= 1'b0;
      hit_if.hit_row   <= '0;
      hit_if.hit_col   <= '0;
    end else if (wave_reset) begin
      alive            <= ALL_ALIVE;
      hit_if.hit_valid <= 1'b0;
    end else begin
      if (hit_if.hit_valid && hit_if.hit_ready) hit_if.hit_valid <= 1'b0;
      if (snap) begin
        bullet_hit <= '0;
        b_idx      <= '0;
      end
      if (kill_fire) begin
        alive[kill_row][kill_col] <= 1'b0;
        bullet_hit[b_idx]         <= 1'b1;
        hit_if.hit_row            <= kill_row;
        hit_if.hit_col            <= kill_col;
        hit_if.hit_valid          <= 1'b1;
      end
      if (advance) b_idx <= b_idx + 1'b1;
    end
  end

  // Population count of the alive grid
  always_comb begin
    alive_count = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_INVADERS; c++)
        alive_count = alive_count + CNT_W'(alive[r][c]);
  end

  assign all_dead = (alive_count == '0);

`ifdef COLLISION_ENGINE_SCORE_EN
  logic [16:0] score_sum;

  // Lower rows are worth more: POINTS * (NUM_ROWS - row)
  always_comb begin
    score_sum = {1'b0, score} + 17'(POINTS * (NUM_ROWS - int'(hit_if.hit_row)));
  end

  // Saturating accumulator, advanced once per accepted kill
  always_ff @(posedge clk) begin
    if (rst) begin
      score <= '0;
    end else if (!wave_reset && hit_if.hit_valid && hit_if.hit_ready) begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`else
  // Scoring not built in; POINTS is referenced only so it stays visible.
  assign score = 16'(POINTS) & 16'h0000;
`endif

endmodule
